// File: rtl/aes_inv_cipher_ctrl_if.sv
// Block stream, round-key port and status signals of the AES inverse-cipher sequencer.
// The slave modport is the sequencer side. The master modport is the environment side (upstream, key store, consumer).
`timescale 1ns/1ps
interface aes_inv_cipher_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;
  logic         busy;

  modport master (
    output in_valid, in, rk, out_ready,
    input  in_ready, rk_idx, out_valid, out, busy
  );

  modport slave (
    input  in_valid, in, rk, out_ready,
    output in_ready, rk_idx, out_valid, out, busy
  );
endinterface

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative FIPS-197 inverse cipher: one round per clock around a single 128-bit state register.
// Round keys are read combinationally from an external key store via rk_idx/rk.
`timescale 1ns/1ps
module aes_inv_cipher_ctrl #(
  parameter int NR = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_inv_cipher_ctrl_if.slave   bus
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_inv_cipher_ctrl: NR must be 10, 12 or 14");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [3:0] CNT_INIT = 4'(NR - 1);

  // GF(2^8) arithmetic modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128;
    x2   = gmul(x, x);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    return gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
  endfunction

  // Inverse S-box: undo the affine map, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  // Bytes are column-major: byte r+4c sits at [127-8(r+4c) -: 8].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c      -: 8];
      a1 = s[127 - 32*c - 8  -: 8];
      a2 = s[127 - 32*c - 16 -: 8];
      a3 = s[127 - 32*c - 24 -: 8];
      o[127 - 32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
      };
    end
    return o;
  endfunction

  fsm_e         fsm, fsm_next;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] ark;
  logic [127:0] round_out;

  // Shared round datapath; FINAL simply skips the InvMixColumns stage.
  assign ark       = inv_sub_bytes(inv_shift_rows(state_q)) ^ bus.rk;
  assign round_out = inv_mix_columns(ark);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  // NOTE: the wide data register is reset too, so a block aborted by reset can never surface on out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      cnt_q   <= CNT_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    fsm_next      = fsm;
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.in_ready  = 1'b0;
    bus.rk_idx    = 4'd0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.out       = '0;
    case (fsm)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.rk_idx   = NR_IDX;
        if (bus.in_valid) begin
          state_d  = bus.in ^ bus.rk;
          cnt_d    = CNT_INIT;
          fsm_next = (NR > 1) ? ROUND : FINAL;
        end
      end
      ROUND: begin
        bus.busy   = 1'b1;
        bus.rk_idx = cnt_q;
        state_d    = round_out;
        cnt_d      = cnt_q - 4'd1;
        if (cnt_q == 4'd1) fsm_next = FINAL;
      end
      FINAL: begin
        bus.busy   = 1'b1;
        bus.rk_idx = 4'd0;
        state_d    = ark;
        fsm_next   = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out       = state_q;
        if (bus.out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Scoreboard bench for aes_inv_cipher_ctrl: NR=10 and NR=14 instances fed by a key-expansion model.
// Expected plaintexts are queued at stimulus time and popped when each output handshake is seen.
`timescale 1ns/1ps
module tb_aes_inv_cipher_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_cipher_ctrl_if bus ();
  aes_inv_cipher_ctrl_if bus14 ();

  aes_inv_cipher_ctrl #(.NR(10)) dut   (.clk(clk), .rst(rst), .bus(bus));
  aes_inv_cipher_ctrl #(.NR(14)) dut14 (.clk(clk), .rst(rst), .bus(bus14));

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

  int checks = 0;
  int errors = 0;

  logic [127:0] keys   [2][16];
  logic [127:0] keys14 [16];
  logic         offer_sel  = 1'b0;
  logic         active_sel = 1'b0;
  int           accept_cnt      = 0;
  int           accept14_cnt    = 0;
  int           cyc             = 0;
  int           last_accept_cyc = 0;
  logic [127:0] exp_q   [$];
  logic [127:0] exp14_q [$];
  logic [127:0] exp_v, exp14_v;

  // Key store: the block being offered selects its own key set; a block in flight keeps the latched one.
  assign bus.rk   = keys[bus.in_ready ? offer_sel : active_sel][bus.rk_idx];
  assign bus14.rk = keys14[bus14.rk_idx];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.in_valid && bus.in_ready) begin
      accept_cnt      <= accept_cnt + 1;
      last_accept_cyc <= cyc;
      active_sel      <= offer_sel;
    end
    if (!rst && bus14.in_valid && bus14.in_ready) accept14_cnt <= accept14_cnt + 1;
  end

  // Scoreboard: every output handshake must match the oldest queued plaintext.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_out got %h with empty queue", bus.out);
      end else begin
        exp_v = exp_q.pop_front();
        if (bus.out !== exp_v) begin
          errors++;
          $display("FAIL sb_out got %h exp %h", bus.out, exp_v);
        end
      end
    end
    if (!rst && bus14.out_valid && bus14.out_ready) begin
      checks++;
      if (exp14_q.size() == 0) begin
        errors++;
        $display("FAIL sb14_unexpected_out got %h with empty queue", bus14.out);
      end else begin
        exp14_v = exp14_q.pop_front();
        if (bus14.out !== exp14_v) begin
          errors++;
          $display("FAIL sb14_out got %h exp %h", bus14.out, exp14_v);
        end
      end
    end
  end

  // Forward-cipher key-expansion model.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gm(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [2047:0] expand_key(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [2047:0] res;
    int            nr;
    nr   = nk + 6;
    rcon = 8'h01;
    res  = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) res[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one block on the NR=10 port and wait (bounded) for its accept edge.
  task automatic send_block(input logic [127:0] ct, input logic [127:0] pt, input logic sel);
    int start;
    start        = accept_cnt;
    offer_sel    = sel;
    bus.in       = ct;
    bus.in_valid = 1'b1;
    exp_q.push_back(pt);
    for (int i = 0; i < 40 && accept_cnt == start; i++) step();
    checks++;
    if (accept_cnt == start) begin
      errors++;
      $display("FAIL accept_timeout got no accept within 40 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < 60) begin
      step();
      edges++;
    end
  endtask

  task automatic test_key_table();
    checks++;
    if (keys[0][10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      errors++;
      $display("FAIL key_table_rk10 got %h exp 13111d7fe3944a17f307a78b4d2b30c5", keys[0][10]);
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    offer_sel       = 1'b0;
    bus.in          = C1_CT;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    bus14.in        = C3_CT;
    bus14.in_valid  = 1'b0;
    bus14.out_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got in_ready=%b out_valid=%b busy=%b exp 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.rk_idx !== 4'd10 || bus.out !== '0) begin
      errors++;
      $display("FAIL reset_idx_out got rk_idx=%0d out=%h exp 10 and zero", bus.rk_idx, bus.out);
    end
    checks++;
    if (bus14.rk_idx !== 4'd14) begin
      errors++;
      $display("FAIL reset_idx_nr14 got %0d exp 14", bus14.rk_idx);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_beats_valid got busy=%b in_ready=%b exp 0 1", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_fips_c1();
    int edges;
    send_block(C1_CT, C1_PT, 1'b0);
    wait_out_valid(edges);
    checks++;
    if (edges !== 10) begin
      errors++;
      $display("FAIL c1_latency got %0d edges exp 10", edges);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== '0) begin
      errors++;
      $display("FAIL c1_after_handshake got out_valid=%b in_ready=%b out=%h exp 0 1 zero",
               bus.out_valid, bus.in_ready, bus.out);
    end
  endtask

  task automatic test_rk_idx_seq();
    offer_sel    = 1'b1;
    bus.in       = B_CT;
    bus.in_valid = 1'b1;
    exp_q.push_back(B_PT);
    #1;
    checks++;
    if (bus.rk_idx !== 4'd10) begin
      errors++;
      $display("FAIL rk_idx_accept got %0d exp 10", bus.rk_idx);
    end
    for (int k = 9; k >= 0; k--) begin
      step();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.rk_idx !== 4'(k) || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL rk_idx_seq got rk_idx=%0d busy=%b exp %0d 1", bus.rk_idx, bus.busy, k);
      end
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.rk_idx !== 4'd0) begin
      errors++;
      $display("FAIL rk_idx_done got out_valid=%b rk_idx=%0d exp 1 0", bus.out_valid, bus.rk_idx);
    end
    step();
  endtask

  task automatic test_backpressure();
    int edges;
    int acc0;
    bus.out_ready = 1'b0;
    send_block(C1_CT, C1_PT, 1'b0);
    wait_out_valid(edges);
    checks++;
    if (edges !== 10) begin
      errors++;
      $display("FAIL bp_latency got %0d edges exp 10", edges);
    end
    acc0         = accept_cnt;
    offer_sel    = 1'b1;
    bus.in       = B_CT;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (bus.out !== C1_PT || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || accept_cnt !== acc0) begin
        errors++;
        $display("FAIL bp_stall cycle %0d got out=%h out_valid=%b in_ready=%b accepts=%0d exp %h 1 0 %0d",
                 i, bus.out, bus.out_valid, bus.in_ready, accept_cnt, C1_PT, acc0);
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || accept_cnt !== acc0) begin
      errors++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b accepts=%0d exp 1 0 %0d",
               bus.in_ready, bus.out_valid, accept_cnt, acc0);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    int n;
    send_block(C1_CT, C1_PT, 1'b0);
    n = 0;
    while (bus.rk_idx !== 4'd5 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (bus.rk_idx !== 4'd5) begin
      errors++;
      $display("FAIL mid_find_idx5 got %0d exp 5", bus.rk_idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.rk_idx !== 4'd10 || bus.out !== '0) begin
      errors++;
      $display("FAIL mid_reset got out_valid=%b in_ready=%b busy=%b rk_idx=%0d out=%h exp 0 1 0 10 zero",
               bus.out_valid, bus.in_ready, bus.busy, bus.rk_idx, bus.out);
    end
    send_block(C1_CT, C1_PT, 1'b0);
    wait_out_valid(edges);
    checks++;
    if (edges !== 10) begin
      errors++;
      $display("FAIL mid_rerun_latency got %0d edges exp 10", edges);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int first_cyc;
    int n;
    bus.out_ready = 1'b1;
    send_block(C1_CT, C1_PT, 1'b0);
    first_cyc = last_accept_cyc;
    send_block(B_CT, B_PT, 1'b1);
    checks++;
    if (last_accept_cyc - first_cyc !== 12) begin
      errors++;
      $display("FAIL b2b_spacing got %0d cycles exp 12", last_accept_cyc - first_cyc);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got %0d pending outputs exp 0", exp_q.size());
    end
    step();
  endtask

  task automatic test_nr14();
    int start;
    int edges;
    start          = accept14_cnt;
    bus14.in       = C3_CT;
    bus14.in_valid = 1'b1;
    exp14_q.push_back(C3_PT);
    for (int i = 0; i < 40 && accept14_cnt == start; i++) step();
    bus14.in_valid = 1'b0;
    checks++;
    if (accept14_cnt == start) begin
      errors++;
      $display("FAIL nr14_accept_timeout got no accept within 40 cycles");
    end
    edges = 0;
    while (!bus14.out_valid && edges < 60) begin
      step();
      edges++;
    end
    checks++;
    if (edges !== 14) begin
      errors++;
      $display("FAIL nr14_latency got %0d edges exp 14", edges);
    end
    step();
    checks++;
    if (exp14_q.size() != 0 || bus14.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL nr14_drain got pending=%0d in_ready=%b exp 0 1", exp14_q.size(), bus14.in_ready);
    end
  endtask

  initial begin
    logic [2047:0] kx;
    kx = expand_key({C1_KEY, 128'h0}, 4);
    for (int r = 0; r < 16; r++) keys[0][r] = kx[r*128 +: 128];
    kx = expand_key({B_KEY, 128'h0}, 4);
    for (int r = 0; r < 16; r++) keys[1][r] = kx[r*128 +: 128];
    kx = expand_key(C3_KEY, 8);
    for (int r = 0; r < 16; r++) keys14[r] = kx[r*128 +: 128];

    test_key_table();
    test_reset();
    test_fips_c1();
    test_rk_idx_seq();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_nr14();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
